// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the PE array drain path
package pe_pkg;
    localparam int ACC_BW_DEF = 32;
    localparam int MUL_BW_DEF = 16;

    typedef logic signed [ACC_BW_DEF-1:0] acc_t;
    typedef logic signed [MUL_BW_DEF-1:0] mul_t;

    localparam mul_t MUL_MAX = mul_t'({1'b0, {(MUL_BW_DEF-1){1'b1}}});
    localparam mul_t MUL_MIN = mul_t'({1'b1, {(MUL_BW_DEF-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} drain_state_e;
endpackage

// File: rtl/acc_sat.sv
// rtl/acc_sat.sv - accumulator to multiplier format shift-and-saturate
module acc_sat
    import pe_pkg::*;
#(
    parameter int ACC_BW = $bits(acc_t),
    parameter int MUL_BW = $bits(mul_t),
    parameter int FRA_BW = 10
) (
    input  logic [ACC_BW-1:0] acc,
    output logic [MUL_BW-1:0] mul
);
    localparam logic signed [ACC_BW-1:0] HI = {{(ACC_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] LO = {{(ACC_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

    logic signed [ACC_BW-1:0] t;

    assign t = $signed(acc) >>> FRA_BW;

    always_comb begin
        mul = t[MUL_BW-1:0];
        if (t > HI) begin
            mul = {1'b0, {(MUL_BW-1){1'b1}}};
        end else if (t < LO) begin
            mul = {1'b1, {(MUL_BW-1){1'b0}}};
        end
    end
endmodule

// File: rtl/pe_drain.sv
// rtl/pe_drain.sv - de-skews systolic array column outputs into converted rows for the host
module pe_drain
    import pe_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int INT_BW     = 5,
    parameter int FRA_BW     = 10,
    parameter int MUL_BW     = 16,
    parameter int ACC_BW     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_CW     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [ROW_CW-1:0]      nrow_i,
    input  logic [COLS*ACC_BW-1:0] col_i,
    output logic [COLS*MUL_BW-1:0] row_o,
    output logic                   row_valid_o,
    input  logic                   row_ready_i,
    output logic                   row_last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ovf_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ROW_CW + $clog2(COLS) + 1;

    if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_bad_cfg
        $error("pe_drain: MUL_BW must equal 1+INT_BW+FRA_BW");
    end

    drain_state_e state, state_d;
    logic                   done_d;
    logic [CW-1:0]          cnt;
    logic [ROW_CW-1:0]      nrow_q;
    logic [CW-1:0]          last_k;
    logic [COLS*ACC_BW-1:0] aligned;
    logic [COLS*MUL_BW-1:0] conv;
    logic [COLS*MUL_BW-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic                   wr_req, wr_last, full, pop, push;

    // Column c is delayed COLS-1-c cycles so every column of a row lines up together.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign aligned[c*ACC_BW +: ACC_BW] = col_i[c*ACC_BW +: ACC_BW];
        end else begin : g_pipe
            logic [ACC_BW-1:0] pipe [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= col_i[c*ACC_BW +: ACC_BW];
                    for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign aligned[c*ACC_BW +: ACC_BW] = pipe[D-1];
        end

        acc_sat #(.ACC_BW(ACC_BW), .MUL_BW(MUL_BW), .FRA_BW(FRA_BW)) u_sat (
            .acc (aligned[c*ACC_BW +: ACC_BW]),
            .mul (conv[c*MUL_BW +: MUL_BW])
        );
    end

    assign last_k      = CW'(nrow_q) + CW'(COLS - 2);
    assign row_valid_o = (count != '0);
    assign full        = (count == (PW+1)'(FIFO_DEPTH));
    assign pop         = row_valid_o & row_ready_i;
    assign wr_req      = (state == CAPTURE) && (cnt >= CW'(COLS - 1));
    assign wr_last     = (cnt == last_k);
    assign push        = wr_req & (~full | pop);
    assign row_o       = mem[rd_ptr];
    assign row_last_o  = row_valid_o & last_mem[rd_ptr];
    assign busy_o      = (state != IDLE);

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (nrow_i != '0) state_d = CAPTURE;
                    else              done_d  = 1'b1;
                end
            end
            CAPTURE: begin
                if (wr_req && wr_last) state_d = FLUSH;
            end
            FLUSH: begin
                // An empty FIFO here means the tagged last row was dropped on overflow.
                if ((pop && row_last_o) || !row_valid_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            state  <= state_d;
            done_o <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            nrow_q <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                cnt    <= CW'(1);
                nrow_q <= nrow_i;
                ovf_o  <= 1'b0;
            end else if (state == CAPTURE) begin
                cnt <= cnt + CW'(1);
            end
            if (wr_req && full && !pop) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_mem <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]      <= conv;
                last_mem[wr_ptr] <= wr_last;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_pe_drain.sv
// tb/tb_pe_drain.sv - directed self-checking bench for pe_drain
module tb_pe_drain;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [7:0]   nrow_i = '0;
    logic [127:0] col_i = '0;
    logic [63:0]  row_o;
    logic         row_valid_o, row_ready_i, row_last_o, busy_o, done_o, ovf_o;

    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    logic [31:0] vals [8][4];

    always #5 clk = ~clk;

    pe_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .nrow_i      (nrow_i),
        .col_i       (col_i),
        .row_o       (row_o),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_last_o  (row_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the skewed array output for cycle k: column c carries row k-c.
    task automatic drive(input int k, input int nrow, input bit st);
        start_i = st;
        nrow_i  = st ? 8'(nrow) : 8'd0;
        for (int c = 0; c < 4; c++) begin
            if (k - c >= 0 && k - c < nrow) col_i[c*32 +: 32] = vals[k-c][c];
            else                            col_i[c*32 +: 32] = 32'h0;
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        return {16'(r*4+4), 16'(r*4+3), 16'(r*4+2), 16'(r*4+1)};
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) vals[r][c] = 32'((r*4 + c + 1) << 10);
    endtask

    initial begin
        row_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(row_valid_o), 64'd0);
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_done",  64'(done_o),      64'd0);
        chk("rst_ovf",   64'(ovf_o),       64'd0);
        chk("rst_last",  64'(row_last_o),  64'd0);
        chk("rst_row",   row_o,            64'd0);
        rst_n = 1'b1;
        tick();

        // nrow=2, constant 0x0010_0000 -> 0x0400 elements at cycles 4 and 5
        for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) vals[r][c] = 32'h0010_0000;
        row_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(k, 2, k == 0);
            chk("t1_valid", 64'(row_valid_o), 64'(k == 4 || k == 5));
            chk("t1_last",  64'(row_last_o),  64'(k == 5));
            chk("t1_done",  64'(done_o),      64'(k == 6));
            chk("t1_busy",  64'(busy_o),      64'(k >= 1 && k <= 5));
            if (k == 4 || k == 5) chk("t1_row", row_o, 64'h0400_0400_0400_0400);
            tick();
        end

        // saturation corners, one row
        vals[0][0] = 32'h7FFF_FFFF;
        vals[0][1] = 32'h8000_0000;
        vals[0][2] = 32'hFFFF_FC00;
        vals[0][3] = 32'h0000_03FF;
        for (int k = 0; k < 7; k++) begin
            drive(k, 1, k == 0);
            chk("t2_valid", 64'(row_valid_o), 64'(k == 4));
            chk("t2_done",  64'(done_o),      64'(k == 5));
            if (k == 4) begin
                chk("t2_row",  row_o,            64'h0000_FFFF_8000_7FFF);
                chk("t2_last", 64'(row_last_o),  64'd1);
            end
            tick();
        end

        // nrow=6 with host stalled: rows 4 and 5 overflow, then drain
        fill_ramp();
        row_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(k, 6, k == 0 || k == 9);
            chk("t3_ovf",   64'(ovf_o),       64'(k >= 8));
            chk("t3_valid", 64'(row_valid_o), 64'(k >= 4));
            chk("t3_busy",  64'(busy_o),      64'(k >= 1));
            if (k == 9) chk("t3_head", row_o, exp_row(0));
            tick();
        end
        drive(10, 6, 1'b0);
        row_ready_i = 1'b1;
        chk("t3_ovf_kept", 64'(ovf_o),  64'd1);
        chk("t3_no_done",  64'(done_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_dvalid", 64'(row_valid_o), 64'd1);
            chk("t3_drow",   row_o,            exp_row(i));
            chk("t3_dlast",  64'(row_last_o),  64'd0);
            tick();
        end
        chk("t3_empty",  64'(row_valid_o), 64'd0);
        chk("t3_busy14", 64'(busy_o),      64'd1);
        chk("t3_done14", 64'(done_o),      64'd0);
        tick();
        chk("t3_done",   64'(done_o),      64'd1);
        chk("t3_idle",   64'(busy_o),      64'd0);
        tick();
        chk("t3_done_pulse", 64'(done_o),  64'd0);

        // nrow=0 start: immediate done, clears ovf
        drive(0, 0, 1'b1);
        chk("t5_busy0", 64'(busy_o), 64'd0);
        chk("t5_ovf0",  64'(ovf_o),  64'd1);
        tick();
        drive(1, 0, 1'b0);
        chk("t5_done1", 64'(done_o), 64'd1);
        chk("t5_busy1", 64'(busy_o), 64'd0);
        chk("t5_ovf1",  64'(ovf_o),  64'd0);
        tick();
        chk("t5_done2", 64'(done_o), 64'd0);
        chk("t5_busy2", 64'(busy_o), 64'd0);

        // nrow=3 with ready toggling
        fill_ramp();
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            drive(k, 3, k == 0);
            row_ready_i = (k % 2 == 0);
            chk("t4_valid", 64'(row_valid_o), 64'(k >= 4 && k <= 8));
            chk("t4_done",  64'(done_o),      64'(k == 9));
            chk("t4_busy",  64'(busy_o),      64'(k >= 1 && k <= 8));
            if (row_valid_o) begin
                chk("t4_row",  row_o,           exp_row(idx));
                chk("t4_last", 64'(row_last_o), 64'(idx == 2));
                if (row_ready_i) idx++;
            end
            tick();
        end
        chk("t4_rows", 64'(idx), 64'd3);

        // reset in cycle 3 of an nrow=4 job, then a clean job
        row_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k, 4, k == 0);
            if (k == 3) chk("t6_busy_pre", 64'(busy_o), 64'd1);
            if (k < 3) tick();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(row_valid_o), 64'd0);
        chk("t6_busy",  64'(busy_o),      64'd0);
        chk("t6_done",  64'(done_o),      64'd0);
        chk("t6_row",   row_o,            64'd0);
        chk("t6_last",  64'(row_last_o),  64'd0);
        drive(20, 0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_quiet_done",  64'(done_o),      64'd0);
            chk("t6_quiet_valid", 64'(row_valid_o), 64'd0);
        end
        vals[0][0] = 32'h7FFF_FFFF;
        vals[0][1] = 32'h8000_0000;
        vals[0][2] = 32'hFFFF_FC00;
        vals[0][3] = 32'h0000_03FF;
        for (int k = 0; k < 7; k++) begin
            drive(k, 1, k == 0);
            chk("t6_nvalid", 64'(row_valid_o), 64'(k == 4));
            chk("t6_ndone",  64'(done_o),      64'(k == 5));
            if (k == 4) chk("t6_nrow", row_o, 64'h0000_FFFF_8000_7FFF);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_drain.md
Name: pe_drain

Overview:
- Output collector on the bottom edge of the PE systolic array.
- Reads the skewed o_o results of COLS columns and de-skews them into whole rows.
- Converts each result from the accumulator fixed-point format (ACC_BW, 2*FRA_BW fraction bits) to the multiplier format (MUL_BW, Q INT_BW.FRA_BW) with saturation.
- Buffers rows in a small FIFO and presents them to the host through a valid/ready interface.

Parameters:
- COLS, 4, number of array columns drained.
- INT_BW, 5, integer bits of the MUL_BW format.
- FRA_BW, 10, fraction bits of the MUL_BW format; ACC values carry 2*FRA_BW fraction bits.
- MUL_BW, 16, output element width; must equal 1+INT_BW+FRA_BW.
- ACC_BW, 32, input element width.
- FIFO_DEPTH, 4, row buffer depth (power of 2).
- ROW_CW, 8, width of the row-count input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- start_i  in  1  one-cycle pulse; column-0 row-0 data is on col_i in the same cycle.
- nrow_i  in  ROW_CW  number of rows to drain; sampled with start_i.
- col_i  in  COLS*ACC_BW  o_o of the bottom PE of each column; slice c = col_i[c*ACC_BW +: ACC_BW].
- row_o  out  COLS*MUL_BW  converted row; slice c = column c.
- row_valid_o  out  1  row_o valid.
- row_ready_i  in  1  host accepts row.
- row_last_o  out  1  row_o is the final row of the job.
- busy_o  out  1  job in progress (CAPTURE or FLUSH).
- done_o  out  1  one-cycle pulse at job end.
- ovf_o  out  1  sticky FIFO-overflow flag; cleared by the next accepted start_i.

Behaviour:
- Reset: all outputs, FIFO pointers, counters and skew registers cleared; state IDLE.
- Skew timing: column c, row r is on col_i at cycle r+c, where cycle 0 is the start_i cycle.
- De-skew: column c passes through COLS-1-c registers that shift every cycle unconditionally. Column COLS-1 has zero delay. Row r is aligned at cycle r+COLS-1.
- Conversion, per element (acc_sat):
  - t = v >>> FRA_BW (arithmetic shift, truncate toward -inf).
  - If t > 2^(MUL_BW-1)-1, output 0x7FFF.
  - If t < -2^(MUL_BW-1), output 0x8000.
  - Otherwise output t[MUL_BW-1:0].
- Capture counter cnt is 0 in cycle 0 and increments each CAPTURE cycle.
- FIFO write occurs in cycle k when COLS-1 <= k <= nrow+COLS-2. Aligned row index = k-(COLS-1). The last-row tag is set for row nrow-1.
- Write latency: the earliest row_valid_o for row r is cycle r+COLS. row_o is FIFO head, registered.
- FSM:
  - IDLE: start_i with nrow_i!=0 -> CAPTURE; busy_o=1 from cycle 1.
  - IDLE: start_i with nrow_i==0 -> done_o pulses in cycle 1; stays IDLE; ovf_o cleared.
  - CAPTURE: after the write of row nrow-1 -> FLUSH.
  - FLUSH: when the row with last tag is handshaken (valid&ready) -> IDLE; done_o pulses the next cycle; busy_o drops the same cycle done_o rises.
- Handshake:
  - Transfer occurs when row_valid_o & row_ready_i.
  - row_o, row_valid_o and row_last_o are held stable while valid and not ready.
  - row_ready_i may toggle freely.
- Full FIFO: the array cannot stall. A write into a full FIFO is dropped and ovf_o is set, unless a pop occurs in the same cycle, in which case the write succeeds. If the dropped row is the last row, FLUSH exits as soon as the FIFO empties.
- Empty FIFO: row_valid_o=0. No combinational bypass: a row is visible the cycle after its write.
- start_i while busy: ignored, no effect on ovf_o.
- Reset mid-job: FIFO contents and the job are discarded; no done_o pulse.

Decomposition:
- pe_pkg holds:
  - drain_state_e {IDLE, CAPTURE, FLUSH};
  - MUL_MAX / MUL_MIN saturation constants;
  - acc_t / mul_t typedefs derived from the ACC_BW/MUL_BW defaults.
- One sub-module, acc_sat: combinational ACC_BW->MUL_BW shift-and-saturate, instantiated COLS times.
- The FIFO is inline.

Test Plan:
- COLS=4, nrow=2, col_i skewed with every element 0x0010_0000, ready=1 -> rows at cycles 4 and 5, each element 0x0400; row_last_o in cycle 5; done_o in cycle 6.
- Per-column values 0x7FFF_FFFF, 0x8000_0000, 0xFFFF_FC00, 0x0000_03FF -> row_o elements 0x7FFF, 0x8000, 0xFFFF, 0x0000.
- nrow=6, ready=0 throughout capture, FIFO_DEPTH=4 -> 4 rows kept, ovf_o=1, rows 4-5 dropped; raise ready -> 4 rows drained, then done_o.
- nrow=3, ready toggling 1/0 each cycle -> 3 rows in order, each held stable while stalled, single done_o.
- nrow=0 start -> done_o in cycle 1, busy_o never high. Second start mid-job -> ignored.
- rst_n low in cycle 3 of an nrow=4 job -> all outputs 0, no done_o. A new job after reset completes normally.
